// File: rtl/btn_counter.sv
// Two debounced pushbuttons drive a modulo-64 up/down counter with active-low LED output.
// Each button: 2-flop synchronizer, debounce FSM, single-cycle press strobe.

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [1:0]    r_sync;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_pulse;
  logic          w_pulse_nxt;
  logic          w_pressed;

  // Synchronizer resets to "released" so a held button needs a full debounce after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], i_btn_n};
  end

  assign w_pressed = ~r_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pressed) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_pressed) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST) begin
          // The only transition that emits a strobe.
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!w_pressed) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_pressed) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_pulse = r_pulse;

endmodule

module btn_counter #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_n,
  input  logic       btn_dn_n,
  output logic       up_pulse,
  output logic       dn_pulse,
  output logic [5:0] count,
  output logic [5:0] led
);

  localparam int NUM_BTN = 2;

  logic [NUM_BTN-1:0] w_btn_n;
  logic [NUM_BTN-1:0] w_pulse;
  logic [5:0]         r_count;

  // Bit 0 = up, bit 1 = down.
  assign w_btn_n = {btn_dn_n, btn_up_n};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .i_btn_n (w_btn_n[g]),
      .o_pulse (w_pulse[g])
    );
  end

  // Simultaneous strobes cancel; 6-bit arithmetic wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case (w_pulse)
        2'b01:   r_count <= r_count + 6'd1;
        2'b10:   r_count <= r_count - 6'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign up_pulse = w_pulse[0];
  assign dn_pulse = w_pulse[1];
  assign count    = r_count;
  assign led      = ~r_count;

endmodule

// File: tb/tb_btn_counter.sv
// Directed bench for btn_counter with DEBOUNCE_CYCLES = 4: table of per-cycle vectors
// plus hand-written reset-while-held sequences.

module tb_btn_counter;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up_n = 1'b1;
  logic       btn_dn_n = 1'b1;
  logic       up_pulse;
  logic       dn_pulse;
  logic [5:0] count;
  logic [5:0] led;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       up_n;
    logic       dn_n;
    logic       e_up;
    logic       e_dn;
    logic [5:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  btn_counter #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up_n (btn_up_n),
    .btn_dn_n (btn_dn_n),
    .up_pulse (up_pulse),
    .dn_pulse (dn_pulse),
    .count    (count),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic eu, input logic ed, input logic [5:0] ec);
    chk({tag, ".up_pulse"}, idx, {5'd0, up_pulse}, {5'd0, eu});
    chk({tag, ".dn_pulse"}, idx, {5'd0, dn_pulse}, {5'd0, ed});
    chk({tag, ".count"},    idx, count, ec);
    chk({tag, ".led"},      idx, led, ~ec);
  endtask

  task automatic add(input int n, input logic u, input logic d, input logic eu, input logic ed,
                     input logic [5:0] c);
    vec_t v;
    v.up_n = u; v.dn_n = d; v.e_up = eu; v.e_dn = ed; v.e_cnt = c;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  // Clean 20-cycle press then 10-cycle release; strobe after edge DC+3, count moves one edge later.
  task automatic press(input logic up, input logic dn, input logic [5:0] c0);
    logic [5:0] c1;
    c1 = c0;
    if (up && !dn) c1 = c0 + 6'd1;
    if (dn && !up) c1 = c0 - 6'd1;
    add(DC + 2, ~up, ~dn, 1'b0, 1'b0, c0);
    add(1,      ~up, ~dn, up,   dn,   c0);
    add(17 - DC, ~up, ~dn, 1'b0, 1'b0, c1);
    add(10, 1'b1, 1'b1, 1'b0, 1'b0, c1);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Hold up, pulse rst (in PRESS_WAIT or PRESSED), keep holding: one pulse after a full debounce.
  task automatic rst_held(input logic in_pressed, input logic [5:0] c0);
    btn_up_n = 1'b0;
    if (in_pressed) begin
      for (int k = 1; k <= DC + 6; k++) begin
        step();
        chk_all("pre_rst_pressed", k, (k == DC + 3), 1'b0, (k >= DC + 4) ? c0 + 6'd1 : c0);
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        step();
        chk_all("pre_rst_wait", k, 1'b0, 1'b0, c0);
      end
    end
    rst = 1'b1;
    #1;
    chk_all("in_rst_async", 0, 1'b0, 1'b0, 6'd0);
    step();
    step();
    chk_all("in_rst_held", 0, 1'b0, 1'b0, 6'd0);
    rst = 1'b0;
    for (int k = 1; k <= DC + 8; k++) begin
      step();
      chk_all("post_rst", k, (k == DC + 3), 1'b0, (k >= DC + 4) ? 6'd1 : 6'd0);
    end
    btn_up_n = 1'b1;
    for (int k = 1; k <= 10; k++) step();
    chk_all("post_rst_release", 0, 1'b0, 1'b0, 6'd1);
  endtask

  initial begin
    // Global bound in case the clock or simulation stalls.
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  initial begin
    // Table construction.
    press(1'b1, 1'b0, 6'd0);                 // clean press 0 -> 1
    // Bounce: low 3, high 1, low 10; strobe timed from second low edge (edge 5 -> pulse after edge 11).
    add(3, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1);
    add(1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1);
    add(6, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1);
    add(1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1);
    add(3, 1'b0, 1'b1, 1'b0, 1'b0, 6'd2);
    add(10, 1'b1, 1'b1, 1'b0, 1'b0, 6'd2);
    press(1'b1, 1'b1, 6'd2);                 // simultaneous: both strobes, count holds
    press(1'b0, 1'b1, 6'd2);
    press(1'b0, 1'b1, 6'd1);
    press(1'b0, 1'b1, 6'd0);                 // 0 -> 63
    press(1'b1, 1'b0, 6'd63);                // 63 -> 0
    // Release glitch while PRESSED: 2 high cycles then low again, no extra strobe.
    add(DC + 2, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    add(1,      1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
    add(5,      1'b0, 1'b1, 1'b0, 1'b0, 6'd1);
    add(2,      1'b1, 1'b1, 1'b0, 1'b0, 6'd1);
    add(12,     1'b0, 1'b1, 1'b0, 1'b0, 6'd1);
    add(10,     1'b1, 1'b1, 1'b0, 1'b0, 6'd1);
    // Long hold: exactly one strobe, no auto-repeat.
    add(DC + 2, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1);
    add(1,      1'b0, 1'b1, 1'b1, 1'b0, 6'd1);
    add(100,    1'b0, 1'b1, 1'b0, 1'b0, 6'd2);
    add(10,     1'b1, 1'b1, 1'b0, 1'b0, 6'd2);

    // Reset state.
    #1;
    chk_all("reset_async", 0, 1'b0, 1'b0, 6'd0);
    for (int k = 0; k < 3; k++) step();
    chk_all("reset_held", 0, 1'b0, 1'b0, 6'd0);
    rst = 1'b0;
    step();
    chk_all("reset_release", 0, 1'b0, 1'b0, 6'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      btn_up_n = tbl[i].up_n;
      btn_dn_n = tbl[i].dn_n;
      step();
      chk_all("tbl", i, tbl[i].e_up, tbl[i].e_dn, tbl[i].e_cnt);
    end

    rst_held(1'b0, 6'd2);
    rst_held(1'b1, 6'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
